// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer2.sv
// Two-entry in-order buffer (head + skid) between instruction memory and IF/ID.
module fetch_buffer2
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  fetch_entry_t push_entry_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [1:0]   occ_o,
    output fetch_entry_t head_o,
    output logic         head_valid_o
);

    fetch_entry_t head_q, head_d;
    fetch_entry_t skid_q, skid_d;
    logic [1:0]   occ_q, occ_d;
    logic         pop_ok;

    assign pop_ok = pop_i && (occ_q != 2'd0);

    always_comb begin
        head_d = head_q;
        skid_d = skid_q;
        occ_d  = occ_q;
        if (flush_i) begin
            // Head contents are kept so pc_if holds its last value while empty.
            occ_d = 2'd0;
        end else begin
            if (pop_ok) begin
                if (occ_q == 2'd2) begin
                    head_d = skid_q;
                end
                occ_d = occ_q - 2'd1;
            end
            if (push_i) begin
                if (occ_d == 2'd0) begin
                    head_d = push_entry_i;
                end else begin
                    skid_d = push_entry_i;
                end
                occ_d = occ_d + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '{instr: NOP_INSTR, pc: 32'h0};
            skid_q <= '{instr: NOP_INSTR, pc: 32'h0};
            occ_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            skid_q <= skid_d;
            occ_q  <= occ_d;
        end
    end

    assign occ_o        = occ_q;
    assign head_o       = head_q;
    assign head_valid_o = (occ_q != 2'd0);

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: owns the fetch PC, issues one-outstanding imem requests and feeds IF/ID.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    output logic         imem_req_valid,
    input  logic         imem_req_ready,
    output logic [31:0]  imem_req_addr,
    input  logic         imem_rsp_valid,
    input  logic [31:0]  imem_rsp_data,
    output logic [31:0]  instr_if,
    output logic [31:0]  pc_if,
    output logic [31:0]  pc_plus4_if,
    output logic         fetch_valid,
    output fetch_state_t dbg_state,
    output logic [1:0]   dbg_occ
);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic [31:0]  req_pc_q;
    logic [1:0]   occ;
    fetch_entry_t head;
    logic         head_valid;
    logic         req_fire;
    logic         buf_push;
    logic         buf_pop;
    logic         unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Handshake: a request transfers on the rising edge where imem_req_valid and
    // imem_req_ready are both high; valid never depends on ready or on imem_rsp_*.
    assign imem_req_valid = rst_n && (state_q == RUN) && (occ != 2'd2) && !redirect_valid;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign buf_push = !redirect_valid && (state_q == WAIT) && imem_rsp_valid;
    assign buf_pop  = !redirect_valid && !stall;

    fetch_buffer2 u_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (buf_push),
        .push_entry_i ('{instr: imem_rsp_data, pc: req_pc_q}),
        .pop_i        (buf_pop),
        .flush_i      (redirect_valid),
        .occ_o        (occ),
        .head_o       (head),
        .head_valid_o (head_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
        end else if (redirect_valid) begin
            pc_q <= {redirect_pc[31:2], 2'b00};
            // An outstanding fetch is from the old path; its response must be dropped.
            case (state_q)
                WAIT, FLUSH: state_q <= imem_rsp_valid ? RUN : FLUSH;
                default:     state_q <= RUN;
            endcase
        end else begin
            case (state_q)
                RUN: begin
                    if (req_fire) begin
                        req_pc_q <= pc_q;
                        pc_q     <= pc_q + 32'd4;
                        state_q  <= WAIT;
                    end
                end
                WAIT, FLUSH: begin
                    if (imem_rsp_valid) begin
                        state_q <= RUN;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign fetch_valid = head_valid;
    assign instr_if    = head_valid ? head.instr : NOP_INSTR;
    assign pc_if       = head.pc;
    assign pc_plus4_if = head.pc + 32'd4;
    assign dbg_state   = state_q;
    assign dbg_occ     = occ;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: random memory/stall/redirect against a queue-based model.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic         stall = 1'b0;
  logic         redirect_valid = 1'b0;
  logic [31:0]  redirect_pc = 32'h0;
  logic         imem_req_valid;
  logic         imem_req_ready = 1'b1;
  logic [31:0]  imem_req_addr;
  logic         imem_rsp_valid = 1'b0;
  logic [31:0]  imem_rsp_data = 32'h0;
  logic [31:0]  instr_if;
  logic [31:0]  pc_if;
  logic [31:0]  pc_plus4_if;
  logic         fetch_valid;
  fetch_state_t dbg_state;
  logic [1:0]   dbg_occ;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_if       (instr_if),
    .pc_if          (pc_if),
    .pc_plus4_if    (pc_plus4_if),
    .fetch_valid    (fetch_valid),
    .dbg_state      (dbg_state),
    .dbg_occ        (dbg_occ)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errs = 0;

  logic [63:0] exp_q[$];      // {instr, pc} that IF/ID should see, in order
  logic [31:0] m_pc;          // next fetch address
  logic [31:0] m_req_pc;      // address of the outstanding fetch
  logic [31:0] m_hold_pc;     // last head pc shown
  bit          m_out;         // a fetch is outstanding
  bit          m_keep;        // its response should be kept

  // memory environment
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          lat_min = 1;
  int          lat_max = 1;
  int          ready_pct = 100;

  logic [31:0] acc_log[$];
  logic [31:0] pc_log[$];
  logic [31:0] pc4_log[$];
  bit          fv_log[$];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic log_chk(input string name, input logic [31:0] q[$], input int idx,
                         input logic [31:0] exp);
    if (idx < q.size()) begin
      chk(name, q[idx], exp);
    end else begin
      n_checks++;
      n_errs++;
      $display("FAIL %s: got no entry %0d expected %h", name, idx, exp);
    end
  endtask

  task automatic bound_chk(input string name, input bit ok);
    n_checks++;
    if (!ok) begin
      n_errs++;
      $display("FAIL %s: got timeout expected condition", name);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pc = 32'h0;
    m_req_pc = 32'h0;
    m_hold_pc = 32'h0;
    m_out = 0;
    m_keep = 0;
    mem_busy = 0;
  endtask

  // ---------------- compare + model, one clock per call ----------------
  task automatic step();
    bit          acc;
    bit          exp_rv;
    logic [31:0] acc_addr;
    logic [31:0] exp_pc;
    fetch_state_t exp_st;
    acc = 0;
    acc_addr = 32'h0;
    @(negedge clk);
    if (rst_n) begin
      if (exp_q.size() > 0) m_hold_pc = exp_q[0][31:0];
      exp_pc = m_hold_pc;
      exp_rv = !m_out && (exp_q.size() < 2) && !redirect_valid;
      exp_st = !m_out ? RUN : (m_keep ? WAIT : FLUSH);
      chk("fetch_valid", {31'b0, fetch_valid}, {31'b0, exp_q.size() > 0});
      chk("instr_if", instr_if, (exp_q.size() > 0) ? exp_q[0][63:32] : NOP_INSTR);
      chk("pc_if", pc_if, exp_pc);
      chk("pc_plus4_if", pc_plus4_if, exp_pc + 32'd4);
      chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
      chk("req_addr", imem_req_addr, m_pc);
      chk("occ", {30'b0, dbg_occ}, exp_q.size());
      chk("state", {30'b0, dbg_state}, {30'b0, exp_st});
      fv_log.push_back(fetch_valid);
      if (fetch_valid) begin
        pc_log.push_back(pc_if);
        pc4_log.push_back(pc_plus4_if);
      end
      acc = imem_req_valid && imem_req_ready;
      acc_addr = imem_req_addr;
      if (acc) acc_log.push_back(acc_addr);

      if (redirect_valid) begin
        exp_q.delete();
        m_pc = {redirect_pc[31:2], 2'b00};
        if (m_out) begin
          if (imem_rsp_valid) m_out = 0;
          else m_keep = 0;
        end
      end else begin
        if (exp_q.size() > 0 && !stall) void'(exp_q.pop_front());
        if (m_out && imem_rsp_valid) begin
          if (m_keep) exp_q.push_back({instr_of(m_req_pc), m_req_pc});
          m_out = 0;
        end
        if (exp_rv && imem_req_ready) begin
          m_out = 1;
          m_keep = 1;
          m_req_pc = m_pc;
          m_pc = m_pc + 32'd4;
        end
      end
    end
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    if (!rst_n) begin
      mem_busy = 0;
    end else begin
      if (acc) begin
        mem_busy = 1;
        mem_cnt = $urandom_range(lat_max, lat_min);
        mem_addr = acc_addr;
      end
      if (mem_busy) begin
        mem_cnt--;
        if (mem_cnt <= 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data = instr_of(mem_addr);
          mem_busy = 0;
        end
      end
    end
    imem_req_ready = ($urandom_range(99, 0) < ready_pct);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_fetch_valid", {31'b0, fetch_valid}, 32'd0);
    chk("rst_instr_if", instr_if, 32'h0000_0013);
    chk("rst_pc_if", pc_if, 32'h0);
    chk("rst_pc_plus4_if", pc_plus4_if, 32'h4);
    model_reset();
    stall = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    acc_log.delete();
    pc_log.delete();
    pc4_log.delete();
    fv_log.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int na;
    int np;
    int i;

    // Straight-line fetch, 1-cycle memory, always ready.
    ready_pct = 100;
    lat_min = 1;
    lat_max = 1;
    imem_req_ready = 1'b1;
    do_reset();
    repeat (8) step();
    log_chk("addr0", acc_log, 0, 32'h0);
    log_chk("addr1", acc_log, 1, 32'h4);
    log_chk("addr2", acc_log, 2, 32'h8);
    log_chk("pc_if0", pc_log, 0, 32'h0);
    log_chk("pc_if1", pc_log, 1, 32'h4);
    log_chk("pc_if2", pc_log, 2, 32'h8);
    log_chk("pc4_0", pc4_log, 0, 32'h4);
    log_chk("pc4_1", pc4_log, 1, 32'h8);
    log_chk("pc4_2", pc4_log, 2, 32'hC);
    for (int k = 2; k < 8; k++) chk("alternate_fv", {31'b0, fv_log[k]}, {31'b0, (k % 2) == 0});

    // Stall for 6 cycles: buffer fills, requests stop, then drains back-to-back.
    stall = 1'b1;
    repeat (6) step();
    chk("stall_occ", {30'b0, dbg_occ}, 32'd2);
    chk("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
    stall = 1'b0;
    np = pc_log.size();
    step();
    step();
    chk("drain_count", pc_log.size(), np + 2);
    if (pc_log.size() >= np + 2) chk("drain_order", pc_log[np + 1], pc_log[np] + 32'd4);

    // Redirect while a kept fetch is outstanding.
    lat_min = 3;
    lat_max = 3;
    for (i = 0; i < 50 && !(m_out && m_keep && !imem_rsp_valid); i++) step();
    bound_chk("wait_for_wait", m_out && m_keep && !imem_rsp_valid);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    na = acc_log.size();
    np = pc_log.size();
    step();
    chk("redir_fv_low", {31'b0, fetch_valid}, 32'd0);
    repeat (14) step();
    log_chk("redir_addr", acc_log, na, 32'h100);
    log_chk("redir_first_pc", pc_log, np, 32'h100);

    // Redirect coinciding with a response while stalled with one entry buffered.
    lat_min = 2;
    lat_max = 2;
    stall = 1'b1;
    for (i = 0; i < 50 && !(m_out && m_keep && imem_rsp_valid && exp_q.size() == 1); i++) step();
    bound_chk("wait_for_rsp", m_out && m_keep && imem_rsp_valid && exp_q.size() == 1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    na = acc_log.size();
    step();
    chk("redir_rsp_fv", {31'b0, fetch_valid}, 32'd0);
    chk("redir_rsp_instr", instr_if, 32'h0000_0013);
    chk("redir_rsp_occ", {30'b0, dbg_occ}, 32'd0);
    stall = 1'b0;
    repeat (8) step();
    log_chk("redir_rsp_addr", acc_log, na, 32'h300);

    // Misaligned target and address wrap.
    lat_min = 1;
    lat_max = 2;
    redirect_valid = 1'b1;
    redirect_pc = 32'h203;
    na = acc_log.size();
    step();
    repeat (8) step();
    log_chk("misaligned_addr", acc_log, na, 32'h200);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    na = acc_log.size();
    step();
    repeat (12) step();
    log_chk("wrap_addr0", acc_log, na, 32'hFFFF_FFFC);
    log_chk("wrap_addr1", acc_log, na + 1, 32'h0);

    // Randomized traffic.
    ready_pct = 70;
    lat_min = 1;
    lat_max = 3;
    for (int c = 0; c < 800; c++) begin
      stall = ($urandom_range(99, 0) < 30);
      if ($urandom_range(99, 0) < 4) begin
        redirect_valid = 1'b1;
        redirect_pc = $urandom();
      end
      step();
    end

    // Asynchronous reset while a fetch is outstanding.
    stall = 1'b0;
    ready_pct = 100;
    for (i = 0; i < 50 && !m_out; i++) step();
    bound_chk("wait_for_outstanding", m_out);
    #2;
    do_reset();
    lat_min = 1;
    lat_max = 1;
    repeat (6) step();
    log_chk("post_reset_addr", acc_log, 0, 32'h0);
    log_chk("post_reset_pc", pc_log, 0, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
